// File: rtl/fp16_add_scheduler.sv
// fp16_add_scheduler
//
// Shares one pipelined FP16 adder between two requesters. Operand pairs
// arrive over valid/ready. A round-robin arbiter issues at most one pair per
// cycle onto the registered adder inputs. A tag pipeline follows each pair
// through the adder latency so its sum can be written into the owner's
// result FIFO. Per-requester credits bound the number of in-flight plus
// buffered results to the FIFO depth, so a FIFO write can never find the
// FIFO full and no result is ever dropped. The block does no arithmetic.
//
// Ports
//   clk_10, reset_10          clock, asynchronous active-low reset
//   reqN_valid/_a/_b/_ready   operand pair from requester N (N = 0, 1)
//   resN_valid/_data/_ready   result FIFO head for requester N
//   add_a, add_b              registered operands driven to the adder
//   add_result                adder output, LATENCY cycles after add_a/add_b
//   add_rst                   active-high adder reset, held one edge past reset
//   busy                      any pair in flight or any result buffered
module fp16_add_scheduler #(
  parameter int LATENCY   = 4,
  parameter int RES_DEPTH = 8
) (
  input  logic        clk_10,
  input  logic        reset_10,
  input  logic        req0_valid,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  output logic        req1_ready,
  output logic        res0_valid,
  output logic [15:0] res0_data,
  input  logic        res0_ready,
  output logic        res1_valid,
  output logic [15:0] res1_data,
  input  logic        res1_ready,
  output logic [15:0] add_a,
  output logic [15:0] add_b,
  input  logic [15:0] add_result,
  output logic        add_rst,
  output logic        busy
);

  localparam int CW = $clog2(RES_DEPTH + 1);
  localparam int PW = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
  localparam logic [PW-1:0] PTR_LAST  = PW'(RES_DEPTH - 1);
  localparam logic [CW-1:0] CRED_INIT = CW'(RES_DEPTH);

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  logic        req_valid [2];
  logic [15:0] req_a     [2];
  logic [15:0] req_b     [2];
  logic [1:0]  res_ready;

  assign req_valid[0] = req0_valid;
  assign req_valid[1] = req1_valid;
  assign req_a[0]     = req0_a;
  assign req_a[1]     = req1_a;
  assign req_b[0]     = req0_b;
  assign req_b[1]     = req1_b;
  assign res_ready    = {res1_ready, res0_ready};

  logic [CW-1:0]  credit_q [2];
  logic [CW-1:0]  credit_d [2];
  logic           ptr_q, ptr_d;
  logic [1:0]     elig, grant;
  logic [15:0]    add_a_q, add_a_d, add_b_q, add_b_d;
  logic           add_rst_q;
  logic [LATENCY:0] tag_vld_q, tag_vld_d;
  logic [LATENCY:0] tag_id_q, tag_id_d;
  logic [15:0]    mem_q    [2][RES_DEPTH];
  logic [PW-1:0]  wr_ptr_q [2];
  logic [PW-1:0]  wr_ptr_d [2];
  logic [PW-1:0]  rd_ptr_q [2];
  logic [PW-1:0]  rd_ptr_d [2];
  logic [CW-1:0]  cnt_q    [2];
  logic [CW-1:0]  cnt_d    [2];
  logic [1:0]     wr_en, pop, not_empty;

  // Arbitration: ready is the grant itself, forced low while reset is held
  // so no transfer is ever signalled during reset.
  always_comb begin
    grant = '0;
    ptr_d = ptr_q;
    for (int n = 0; n < 2; n++) begin
      elig[n] = req_valid[n] && (credit_q[n] != '0);
    end
    if (reset_10) begin
      if (elig[0] && (!elig[1] || !ptr_q)) begin
        grant[0] = 1'b1;
      end else if (elig[1]) begin
        grant[1] = 1'b1;
      end
    end
    if (grant[0]) begin
      ptr_d = 1'b1;
    end else if (grant[1]) begin
      ptr_d = 1'b0;
    end
  end

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  // Issue stage: operands held when idle; tag stage 0 marks the new pair.
  always_comb begin
    add_a_d = add_a_q;
    add_b_d = add_b_q;
    if (grant[0]) begin
      add_a_d = req_a[0];
      add_b_d = req_b[0];
    end else if (grant[1]) begin
      add_a_d = req_a[1];
      add_b_d = req_b[1];
    end
    tag_vld_d = {tag_vld_q[LATENCY-1:0], |grant};
    tag_id_d  = {tag_id_q[LATENCY-1:0], grant[1]};
  end

  // Writeback stage: the last tag stage lines up with add_result.
  assign wr_en[0] = tag_vld_q[LATENCY] && !tag_id_q[LATENCY];
  assign wr_en[1] = tag_vld_q[LATENCY] &&  tag_id_q[LATENCY];

  always_comb begin
    for (int n = 0; n < 2; n++) begin
      not_empty[n] = (cnt_q[n] != '0);
      pop[n]       = res_ready[n] && not_empty[n];
      wr_ptr_d[n]  = wr_ptr_q[n];
      rd_ptr_d[n]  = rd_ptr_q[n];
      cnt_d[n]     = cnt_q[n];
      credit_d[n]  = credit_q[n];
      if (wr_en[n]) begin
        wr_ptr_d[n] = ptr_inc(wr_ptr_q[n]);
      end
      if (pop[n]) begin
        rd_ptr_d[n] = ptr_inc(rd_ptr_q[n]);
      end
      case ({wr_en[n], pop[n]})
        2'b10:   cnt_d[n] = cnt_q[n] + 1'b1;
        2'b01:   cnt_d[n] = cnt_q[n] - 1'b1;
        default: cnt_d[n] = cnt_q[n];
      endcase
      // A credit leaves with a grant and returns only when its result is popped.
      case ({grant[n], pop[n]})
        2'b10:   credit_d[n] = credit_q[n] - 1'b1;
        2'b01:   credit_d[n] = credit_q[n] + 1'b1;
        default: credit_d[n] = credit_q[n];
      endcase
    end
  end

  always_ff @(posedge clk_10 or negedge reset_10) begin
    if (!reset_10) begin
      ptr_q     <= 1'b0;
      add_a_q   <= '0;
      add_b_q   <= '0;
      add_rst_q <= 1'b1;
      tag_vld_q <= '0;
      tag_id_q  <= '0;
      for (int n = 0; n < 2; n++) begin
        credit_q[n] <= CRED_INIT;
        wr_ptr_q[n] <= '0;
        rd_ptr_q[n] <= '0;
        cnt_q[n]    <= '0;
      end
    end else begin
      ptr_q     <= ptr_d;
      add_a_q   <= add_a_d;
      add_b_q   <= add_b_d;
      add_rst_q <= 1'b0;
      tag_vld_q <= tag_vld_d;
      tag_id_q  <= tag_id_d;
      for (int n = 0; n < 2; n++) begin
        credit_q[n] <= credit_d[n];
        wr_ptr_q[n] <= wr_ptr_d[n];
        rd_ptr_q[n] <= rd_ptr_d[n];
        cnt_q[n]    <= cnt_d[n];
      end
    end
  end

  // FIFO storage needs no reset: occupancy counts gate every read.
  always_ff @(posedge clk_10) begin
    for (int n = 0; n < 2; n++) begin
      if (wr_en[n]) begin
        mem_q[n][wr_ptr_q[n]] <= add_result;
      end
    end
  end

  assign res0_valid = not_empty[0];
  assign res1_valid = not_empty[1];
  assign res0_data  = not_empty[0] ? mem_q[0][rd_ptr_q[0]] : '0;
  assign res1_data  = not_empty[1] ? mem_q[1][rd_ptr_q[1]] : '0;
  assign add_a      = add_a_q;
  assign add_b      = add_b_q;
  assign add_rst    = add_rst_q;
  assign busy       = (|tag_vld_q) || (|not_empty);

endmodule

// File: tb/tb_fp16_add_scheduler.sv
module tb_fp16_add_scheduler;

  localparam int LAT   = 4;
  localparam int DEPTH = 8;

  logic        clk_10 = 1'b0;
  logic        reset_10 = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [15:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        req0_ready, req1_ready;
  logic        res0_valid, res1_valid;
  logic [15:0] res0_data, res1_data;
  logic        res0_ready = 1'b0, res1_ready = 1'b0;
  logic [15:0] add_a, add_b, add_result;
  logic        add_rst, busy;

  fp16_add_scheduler #(.LATENCY(LAT), .RES_DEPTH(DEPTH)) dut (
    .clk_10(clk_10), .reset_10(reset_10),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .res0_valid(res0_valid), .res0_data(res0_data), .res0_ready(res0_ready),
    .res1_valid(res1_valid), .res1_data(res1_data), .res1_ready(res1_ready),
    .add_a(add_a), .add_b(add_b), .add_result(add_result),
    .add_rst(add_rst), .busy(busy)
  );

  always #5 clk_10 = ~clk_10;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, want, $time);
    end
  endtask

  // ---------------- FP16 reference arithmetic (via reals) ----------------
  function automatic real p2(input int k);
    real r = 1.0;
    if (k >= 0) repeat (k) r = r * 2.0;
    else repeat (-k) r = r / 2.0;
    return r;
  endfunction

  function automatic real h2r(input logic [15:0] h);
    int  e = int'(h[14:10]);
    int  m = int'(h[9:0]);
    real v;
    if (e == 0) v = real'(m) * p2(-24);
    else        v = real'(1024 + m) * p2(e - 25);
    return h[15] ? -v : v;
  endfunction

  function automatic logic [15:0] r2h(input real r);
    logic s = (r < 0.0);
    real  a = s ? -r : r;
    int   e, q;
    real  sc, fr;
    if (a == 0.0) return {s, 15'd0};
    e = 0;
    while (e < 16 && a >= p2(e + 1)) e++;
    while (e > -14 && a < p2(e)) e--;
    if (e > 15) return {s, 5'h1f, 10'd0};
    sc = a / p2(e - 10);
    q  = $rtoi(sc);
    fr = sc - real'(q);
    if (fr > 0.5 || (fr == 0.5 && (q % 2) == 1)) q++;
    if (q >= 2048) begin q = q / 2; e++; end
    if (e > 15) return {s, 5'h1f, 10'd0};
    if (q < 1024) return {s, 5'd0, 10'(q)};
    return {s, 5'(e + 15), 10'(q - 1024)};
  endfunction

  function automatic logic [15:0] fp_add(input logic [15:0] a, input logic [15:0] b);
    return r2h(h2r(a) + h2r(b));
  endfunction

  function automatic logic [15:0] rnd_fp();
    return {1'($urandom_range(0, 1)), 5'($urandom_range(10, 20)), 10'($urandom_range(0, 1023))};
  endfunction

  // ---------------- Adder model: LAT-cycle pipeline ----------------
  logic [15:0] apipe [LAT];
  always @(posedge clk_10) begin
    if (add_rst) begin
      for (int i = 0; i < LAT; i++) apipe[i] <= '0;
    end else begin
      apipe[0] <= fp_add(add_a, add_b);
      for (int i = 1; i < LAT; i++) apipe[i] <= apipe[i-1];
    end
  end
  assign add_result = apipe[LAT-1];

  // ---------------- Scoreboard state ----------------
  typedef struct { int id; logic [15:0] d; int vis; int acc; } sb_t;
  typedef struct { int id; int cyc; } gl_t;
  typedef struct { int id; logic [15:0] d; int cyc; } got_t;

  sb_t  sb[$];
  gl_t  glog[$];
  got_t got[$];
  int   cyc = 0;
  int   cred [2];
  int   rr = 0;
  int   rel = 0;

  // Issue side: arbitration rules decide who should be granted this cycle;
  // every grant pushes its expected sum and the cycle it becomes visible.
  int   win;
  bit   e0, e1;
  sb_t  ent;
  gl_t  gent;
  always begin
    @(negedge clk_10);
    cyc++;
    if (!reset_10) begin
      chk("rst_req0_ready", int'(req0_ready), 0);
      chk("rst_req1_ready", int'(req1_ready), 0);
      cred[0] = DEPTH;
      cred[1] = DEPTH;
      rr = 0;
      sb.delete();
    end else begin
      e0 = req0_valid && cred[0] > 0;
      e1 = req1_valid && cred[1] > 0;
      if (e0 && e1) win = rr;
      else if (e0)  win = 0;
      else if (e1)  win = 1;
      else          win = -1;
      chk("req0_ready", int'(req0_ready), int'(win == 0));
      chk("req1_ready", int'(req1_ready), int'(win == 1));
      if (win >= 0) begin
        ent.id  = win;
        ent.d   = (win == 0) ? fp_add(req0_a, req0_b) : fp_add(req1_a, req1_b);
        ent.vis = cyc + LAT + 2;
        ent.acc = cyc;
        sb.push_back(ent);
        cred[win]--;
        rr = 1 - win;
        gent.id  = win;
        gent.cyc = cyc;
        glog.push_back(gent);
      end
    end
  end

  // Result side: compare each FIFO head against the oldest expected entry.
  int   idx;
  bit   expv, expb, rv, rdy;
  logic [15:0] rd;
  got_t gt;
  always begin
    @(negedge clk_10);
    #2;
    if (!reset_10) begin
      chk("rst_res0_valid", int'(res0_valid), 0);
      chk("rst_res1_valid", int'(res1_valid), 0);
      chk("rst_res0_data", int'(res0_data), 0);
      chk("rst_res1_data", int'(res1_data), 0);
      chk("rst_add_a", int'(add_a), 0);
      chk("rst_add_b", int'(add_b), 0);
      chk("rst_add_rst", int'(add_rst), 1);
      chk("rst_busy", int'(busy), 0);
      rel = 0;
    end else begin
      chk("add_rst", int'(add_rst), int'(rel == 0));
      if (rel < 2) rel++;
      expb = 1'b0;
      foreach (sb[i]) if (sb[i].acc < cyc) expb = 1'b1;
      chk("busy", int'(busy), int'(expb));
      for (int n = 0; n < 2; n++) begin
        idx = -1;
        for (int i = 0; i < sb.size(); i++) begin
          if (sb[i].id == n) begin idx = i; break; end
        end
        expv = (idx >= 0) && (sb[idx].vis <= cyc);
        rv   = (n == 0) ? res0_valid : res1_valid;
        rd   = (n == 0) ? res0_data  : res1_data;
        rdy  = (n == 0) ? res0_ready : res1_ready;
        chk((n == 0) ? "res0_valid" : "res1_valid", int'(rv), int'(expv));
        if (expv) begin
          chk((n == 0) ? "res0_data" : "res1_data", int'(rd), int'(sb[idx].d));
          if (rdy) begin
            gt.id = n; gt.d = rd; gt.cyc = cyc;
            got.push_back(gt);
            sb.delete(idx);
            cred[n]++;
          end
        end
      end
    end
  end

  // ---------------- Stimulus helpers ----------------
  task automatic step();
    @(posedge clk_10);
    #1;
  endtask

  task automatic zero_inputs();
    req0_valid = 0; req1_valid = 0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
  endtask

  task automatic do_reset();
    step();
    reset_10 = 1'b0;
    repeat (3) begin
      req0_valid = 1'($urandom_range(0, 1));
      req1_valid = 1'($urandom_range(0, 1));
      req0_a = rnd_fp(); req0_b = rnd_fp();
      req1_a = rnd_fp(); req1_b = rnd_fp();
      res0_ready = 1'($urandom_range(0, 1));
      res1_ready = 1'($urandom_range(0, 1));
      step();
    end
    reset_10 = 1'b1;
    zero_inputs();
    res0_ready = 0; res1_ready = 0;
  endtask

  task automatic drain();
    zero_inputs();
    res0_ready = 1; res1_ready = 1;
    repeat (25) step();
    chk("drained", sb.size(), 0);
  endtask

  function automatic int gcount(input int id, input int after_cyc);
    int c = 0;
    foreach (glog[i]) if (glog[i].id == id && glog[i].cyc > after_cyc) c++;
    return c;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  int now_c;
  int n0, n1;

  initial begin
    // Reset held with random inputs, then release.
    do_reset();
    chk("add_rst_release_cycle", int'(add_rst), 1);
    step();
    chk("add_rst_after_edge", int'(add_rst), 0);

    // Single request: 98 + 169 = 267.
    do_reset();
    glog.delete(); got.delete();
    res0_ready = 1; res1_ready = 1;
    req0_a = 16'h5620; req0_b = 16'h5948; req0_valid = 1;
    step();
    req0_valid = 0;
    repeat (10) step();
    chk("single_grants", glog.size(), 1);
    chk("single_results", got.size(), 1);
    if (got.size() == 1 && glog.size() == 1) begin
      chk("single_owner", got[0].id, 0);
      chk("single_data", int'(got[0].d), 16'h5C2C);
      chk("single_latency", got[0].cyc - glog[0].cyc, 6);
    end

    // Contention: 99 - 89 = 10 for req0, 79 - 45 = 34 for req1.
    do_reset();
    glog.delete(); got.delete();
    res0_ready = 1; res1_ready = 1;
    req0_a = 16'h5630; req0_b = 16'hD590; req0_valid = 1;
    req1_a = 16'hD1A0; req1_b = 16'h54F0; req1_valid = 1;
    repeat (4) step();
    zero_inputs();
    repeat (12) step();
    chk("cont_grants", glog.size(), 4);
    for (int i = 0; i < 4 && i < glog.size(); i++) chk("cont_order", glog[i].id, i % 2);
    n0 = 0; n1 = 0;
    foreach (got[i]) begin
      if (got[i].id == 0) begin n0++; chk("cont_res0", int'(got[i].d), 16'h4900); end
      else begin n1++; chk("cont_res1", int'(got[i].d), 16'h5040); end
    end
    chk("cont_n0", n0, 2);
    chk("cont_n1", n1, 2);

    // Credit exhaustion on requester 0 while requester 1 keeps flowing.
    do_reset();
    glog.delete();
    res0_ready = 0; res1_ready = 1;
    req0_valid = 1; req1_valid = 1;
    req0_a = rnd_fp(); req0_b = rnd_fp(); req1_a = rnd_fp(); req1_b = rnd_fp();
    repeat (30) step();
    now_c = cyc;
    chk("exh_req0_grants", gcount(0, 0), 8);
    chk("exh_req1_every_cycle", gcount(1, now_c - 10), 10);
    glog.delete();
    res0_ready = 1;
    step();
    res0_ready = 0;
    repeat (15) step();
    chk("exh_one_more", gcount(0, 0), 1);
    drain();

    // Random traffic, requester 0 popping rarely to sit near zero credit.
    do_reset();
    repeat (150) begin
      req0_valid = ($urandom_range(0, 3) != 0);
      req1_valid = 1'($urandom_range(0, 1));
      req0_a = rnd_fp(); req0_b = rnd_fp();
      req1_a = rnd_fp(); req1_b = rnd_fp();
      res0_ready = ($urandom_range(0, 3) == 0);
      res1_ready = 1'($urandom_range(0, 1));
      step();
    end
    drain();

    // Reset with 3 pairs in flight and 2 results buffered.
    do_reset();
    glog.delete();
    res0_ready = 0; res1_ready = 0;
    req0_a = rnd_fp(); req0_b = rnd_fp(); req0_valid = 1;
    repeat (5) step();
    req0_valid = 0;
    repeat (2) step();
    chk("mid_grants", glog.size(), 5);
    chk("mid_busy_before", int'(busy), 1);
    chk("mid_res0_before", int'(res0_valid), 1);
    reset_10 = 0;
    #1;
    chk("mid_res0_async", int'(res0_valid), 0);
    chk("mid_busy_async", int'(busy), 0);
    repeat (2) step();
    reset_10 = 1;
    res0_ready = 1; res1_ready = 1;
    repeat (12) step();
    chk("mid_busy_after", int'(busy), 0);
    glog.delete();
    res0_ready = 0;
    req0_valid = 1;
    repeat (20) step();
    chk("mid_credits", gcount(0, 0), 8);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
